// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO page
// (cycle counter, output port, debug TX FIFO). Optional FIFO: DMEM_DBG_FIFO_EN.
module data_mem_responder #(
   parameter int DEPTH     = 64,
   parameter int DBG_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic [31:0] out_port,
   output logic        dbg_valid,
   input  logic        dbg_ready,
   output logic [31:0] dbg_data,
   output logic        dbg_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(DBG_DEPTH);

   localparam logic [7:0] OFF_CYCLE = 8'h00;
   localparam logic [7:0] OFF_OUT   = 8'h04;
   localparam logic [7:0] OFF_TX    = 8'h08;
   localparam logic [7:0] OFF_STAT  = 8'h0C;

   logic          is_page;
   logic [7:0]    off;
   logic [AW-1:0] idx;
   logic          ram_we;
   logic          out_we;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   cycle_cnt;

   assign is_page = (A[31:8] == 24'hFFFFFF);
   assign off     = A[7:0];
   assign idx     = A[AW+1:2];
   assign ram_we  = WE && !is_page;
   assign out_we  = WE && is_page && (off == OFF_OUT);

   // RAM is deliberately left out of reset so a reset keeps program data.
   always_ff @(posedge clk) begin
      if (ram_we) mem[idx] <= WD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
         out_port  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (out_we) out_port <= WD;
      end
   end

`ifdef DMEM_DBG_FIFO_EN
   logic [31:0] fifo [DBG_DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic [PW:0] count;
   logic        empty;
   logic        full;
   logic        pop;
   logic        push_req;
   logic        push_ok;
   logic        ovf_clr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count    = wr_ptr - rd_ptr;
   assign pop      = !empty && dbg_ready;
   assign push_req = WE && is_page && (off == OFF_TX);
   assign push_ok  = push_req && (!full || pop);
   assign ovf_clr  = WE && is_page && (off == OFF_STAT);

   // When full with a pop, the write lands in the slot being freed this edge.
   always_ff @(posedge clk) begin
      if (push_ok) fifo[wr_ptr[PW-1:0]] <= WD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         dbg_overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_req && !push_ok) dbg_overflow <= 1'b1;
         else if (ovf_clr)         dbg_overflow <= 1'b0;
      end
   end

   assign dbg_valid = !empty;
   assign dbg_data  = empty ? '0 : fifo[rd_ptr[PW-1:0]];
`else
   logic dbg_ready_unused;
   assign dbg_ready_unused = dbg_ready;
   assign dbg_valid        = 1'b0;
   assign dbg_data         = '0;
   assign dbg_overflow     = 1'b0;
`endif

   always_comb begin
      RD = '0;
      if (!is_page) begin
         RD = mem[idx];
      end else begin
         case (off)
            OFF_CYCLE: RD = cycle_cnt;
            OFF_OUT:   RD = out_port;
`ifdef DMEM_DBG_FIFO_EN
            OFF_TX:    RD = 32'(count);
            OFF_STAT:  RD = {29'b0, dbg_overflow, full, empty};
`endif
            default:   RD = '0;
         endcase
      end
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the single-cycle RISC-V core: answers the core's load/store port (DataAdr, WriteData, MemWrite, ReadData) with a word RAM plus a small memory-mapped I/O page. The page holds a free-running cycle counter, a 32-bit output port, and a debug TX FIFO drained by an external valid/ready consumer. Reads are combinational so the core's single-cycle load timing holds. Writes and all peripheral state update on the rising clock edge.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two, ≥ 4.
- DBG_DEPTH, 4: debug FIFO entries; power of two, ≥ 2.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- WE  in  1  store strobe (core MemWrite).
- A  in  32  byte address (core DataAdr); A[1:0] ignored.
- WD  in  32  store data (core WriteData).
- RD  out  32  load data (core ReadData), combinational.
- out_port  out  32  output port register.
- dbg_valid  out  1  FIFO head valid (FIFO not empty).
- dbg_ready  in  1  consumer accepts head.
- dbg_data  out  32  FIFO head word.
- dbg_overflow  out  1  sticky: a push was dropped.

## Operation
- MMIO page: A[31:8] == 24'hFFFFFF; everything else is RAM.
- RAM index = A[log2(DEPTH)+1:2]; upper address bits are ignored, so out-of-range addresses alias.
- RAM contents are not reset.
- RAM write: WE=1 outside the page writes WD at the edge.
- RAM read: RD = mem[index], combinational.
- Page offsets A[7:0]:
  - 0x00 CYCLE: read-only; reads the counter; writes ignored.
  - 0x04 OUT: read/write; reads out_port.
  - 0x08 DBG_TX: a write pushes WD; reads return {(32-log2(DBG_DEPTH)-1)'b0, count}.
  - 0x0C DBG_STAT: reads {29'b0, overflow, full, empty}; any write clears overflow.
  - Any other offset reads 0; writes to it are ignored.
- Cycle counter: +1 every clock; wraps 0xFFFFFFFF → 0.
- FIFO is first-word-fall-through:
  - dbg_valid = !empty.
  - dbg_data = head word; it is 0 when the FIFO is empty.
  - pop = dbg_valid && dbg_ready at the edge.
- Push is accepted if (!full || pop) in the same cycle.
- Push while full with no pop: word dropped, overflow set to 1, FIFO unchanged.
- Simultaneous push and overflow-clear cannot occur, because they target different addresses.

## Timing
- Reset (rst=0, asynchronous) drives: counter=0, out_port=0, FIFO empty (dbg_valid=0, dbg_data=0), dbg_overflow=0, read/write pointers=0.
- RD after reset is combinational on A: page reads return reset values; RAM reads return the unreset contents.
- Counter: reads 0 in the first cycle after rst rises; increments at each edge from then on.
- Store latency: a store at edge N is visible to RD, out_port, dbg_valid and dbg_data from just after edge N.
- Read-during-write at the same address in one cycle returns the old value.
- Pop at edge N: the next head appears after N; dbg_valid falls after N if that was the last entry.
- Push and pop on the same edge: count unchanged.
  - Push and pop when full: the write is accepted into the freed slot.
  - Push when empty: no pop is possible that cycle; count becomes 1.
- Pointers are log2(DBG_DEPTH)+1 bits wide; full/empty come from MSB compare.
- dbg_data may change only on a pop or on a push into an empty FIFO.
- Reset asserted mid-burst: FIFO contents are discarded immediately; out_port and overflow clear; RAM is retained.

## Configuration
- DMEM_DBG_FIFO_EN defined: debug FIFO, DBG_TX and DBG_STAT are built as described.
- Undefined:
  - No FIFO storage is built.
  - DBG_TX writes are ignored.
  - DBG_TX and DBG_STAT reads return 0.
  - dbg_valid=0, dbg_data=0 and dbg_overflow=0 constant; dbg_ready is unused.
  - RAM, CYCLE and OUT behaviour is unchanged.

## Test plan
- RAM: store 0xDEADBEEF at 0x0000_0010, then load 0x0000_0013 and 0x0000_0110 (DEPTH=64 alias) → RD=0xDEADBEEF for both.
- Counter: release reset, wait 10 edges, read 0xFFFF_FF00 → 10. Write 0x1234 to it → next-cycle read is 11 (write ignored).
- OUT: store 0x0000_00A5 to 0xFFFF_FF04 → out_port=0xA5 after the edge and RD readback is 0xA5. Assert rst=0 mid-cycle → out_port=0 immediately.
- FIFO (macro defined, dbg_ready=0): push 1,2,3,4,5 → DBG_STAT reads 0b110, dbg_overflow=1, dbg_data=1. Raise dbg_ready for 4 cycles → observes 1,2,3,4, then dbg_valid=0. Write 0xFFFF_FF0C → overflow=0.
- Full with simultaneous push and pop: fill 4 entries, dbg_ready=1 and push 9 in the same cycle → count stays 4, overflow stays 0, drain order is 2,3,4,9.
- Macro undefined: push to 0xFFFF_FF08 → dbg_valid stays 0, and reads of 0xFFFF_FF08 and 0xFFFF_FF0C return 0.
